// File: rtl/aes_pkg.sv
// Shared constants for the AES result display path: block size, scanner
// state encoding and the default per-byte display interval.
package aes_pkg;

  localparam int AES_BLOCK_BYTES       = 16;
  localparam int SCAN_TICK_DIV_DEFAULT = 50_000_000;

  typedef logic [1:0] scan_state_t;

  localparam scan_state_t ST_IDLE = 2'd0;
  localparam scan_state_t ST_CMP  = 2'd1;
  localparam scan_state_t ST_SCAN = 2'd2;
  localparam scan_state_t ST_DONE = 2'd3;

endpackage

// File: rtl/aes_tick_gen.sv
// Dwell counter for the result scanner. Counts enabled cycles from 0 to
// TICK_DIV-1 and flags the last one so the scanner can step to the next
// byte on that edge. Disabled cycles freeze the count in place.
module aes_tick_gen
  import aes_pkg::*;
#(
  parameter int TICK_DIV = SCAN_TICK_DIV_DEFAULT,
  localparam int CW      = $clog2(TICK_DIV)
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_r;

  // Tick marks the final enabled cycle of a dwell interval.
  assign tick = en && (cnt_r == CNT_LAST);

  // Dwell counter: clear on request, otherwise count enabled cycles and roll at the last one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (en) begin
      if (cnt_r == CNT_LAST) begin
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/aes_result_scanner.sv
// AES result scanner: captures a cipher/decipher result with its expected
// value, reports whether they match, then walks the result one byte at a
// time (byte + index) at a slow, human-visible rate for the 7-segment path.
// Build option: define SCAN_LOOP_EN to make the scan wrap forever instead
// of stopping in DONE after the last byte.
module aes_result_scanner
  import aes_pkg::*;
#(
  parameter int NBYTES   = AES_BLOCK_BYTES,
  parameter int TICK_DIV = SCAN_TICK_DIV_DEFAULT,
  localparam int IW      = $clog2(NBYTES),
  localparam int DW      = 8 * NBYTES
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [DW-1:0] in_expect,
  input  logic          hold,
  output logic [7:0]    byte_out,
  output logic [IW-1:0] byte_idx,
  output logic          match,
  output logic          match_valid,
  output logic          busy,
  output logic          done
);

  localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);

  scan_state_t   state_r;
  logic [DW-1:0] data_r;
  logic [DW-1:0] expect_r;

  logic          xfer_s;
  logic          tick_s;
  logic          tick_en_s;
  logic          tick_clr_s;
  logic          last_s;
  logic [IW-1:0] next_idx_s;
  logic [7:0]    next_byte_s;

  // Ready is a pure decode of the state register; no path from in_valid.
`ifdef SCAN_LOOP_EN
  assign in_ready = (state_r == ST_IDLE);
`else
  assign in_ready = (state_r == ST_IDLE) || (state_r == ST_DONE);
`endif

  assign xfer_s      = in_valid && in_ready;
  assign tick_en_s   = (state_r == ST_SCAN) && !hold;
  assign tick_clr_s  = (state_r == ST_CMP);
  assign last_s      = (byte_idx == IDX_LAST);
  // Index arithmetic wraps naturally modulo NBYTES since NBYTES is a power of two.
  assign next_idx_s  = byte_idx + IW'(1);
  assign next_byte_s = data_r[{next_idx_s, 3'b000} +: 8];

  aes_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (tick_en_s),
    .clr   (tick_clr_s),
    .tick  (tick_s)
  );

  // Scanner FSM with capture registers, comparator and byte display registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      data_r      <= {DW{1'b0}};
      expect_r    <= {DW{1'b0}};
      byte_out    <= 8'h00;
      byte_idx    <= {IW{1'b0}};
      match       <= 1'b0;
      match_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (xfer_s) begin
            data_r   <= in_data;
            expect_r <= in_expect;
            done     <= 1'b0;
            state_r  <= ST_CMP;
          end
        end
        ST_CMP: begin
          match       <= (data_r == expect_r);
          match_valid <= 1'b1;
          byte_idx    <= {IW{1'b0}};
          byte_out    <= data_r[7:0];
          busy        <= 1'b1;
          state_r     <= ST_SCAN;
        end
        ST_SCAN: begin
          if (tick_s) begin
`ifdef SCAN_LOOP_EN
            byte_idx <= next_idx_s;
            byte_out <= next_byte_s;
`else
            if (last_s) begin
              // Last byte stays on display while DONE is reported.
              busy    <= 1'b0;
              done    <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              byte_idx <= next_idx_s;
              byte_out <= next_byte_s;
            end
`endif
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
